mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory and writeback for the supported instruction subset, one phase per clock. It drives every datapath mux, write enable and the 3-bit ALU select, and stalls on a memory ready handshake. It sits between the instruction register (opcode/funct fields), the ALU zero flag and the shared instruction/data memory port.

## Interface
- No parameters (encodings fixed by the ISA subset).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; only high with mem_req.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = sign-extended imm, 3 = imm<<2.
- alu_sel  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- reg_write  out  1  register file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal_op  out  1  sticky illegal-instruction flag (see Configuration).
- state  out  4  current state, for debug.

## Operation
- States: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, R_WB 7, BRANCH 8, JUMP 9, EXEC_I 10, I_WB 11, TRAP 15.
- FETCH: mem_req, iord=0, alu_src_a=0, alu_src_b=1, alu_sel=010. ir_write and pc_write (pc_src=0) assert only when mem_ready=1. Hold in FETCH while mem_ready=0. Exit to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_sel=010 (branch target precompute). Dispatch on opcode:
  - 000000 to EXEC_R.
  - 100011 (LW) or 101011 (SW) to MEM_ADDR.
  - 000100 (BEQ) to BRANCH.
  - 000010 (J) to JUMP.
  - 001000 (ADDI) or 001001 (ADDIU) to EXEC_I.
  - Anything else is illegal.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, add. LW goes to MEM_READ, SW to MEM_WRITE.
- MEM_READ: mem_req, iord=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write, reg_dst=0, mem_to_reg=1, instr_done. Then FETCH.
- MEM_WRITE: mem_req, mem_we, iord=1. Hold until mem_ready; instr_done on the completing cycle. Then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0. alu_sel from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is illegal. Then R_WB.
- R_WB: reg_write, reg_dst=1, mem_to_reg=0, instr_done. Then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, add. Then I_WB.
- I_WB: reg_write, reg_dst=0, mem_to_reg=0, instr_done. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_write_cond, pc_src=1, instr_done. Then FETCH.
- JUMP: pc_write, pc_src=2, instr_done. Then FETCH.
- Any output not listed for a state is 0.

## Timing
- Cycles with zero wait (FETCH through last state):
  - R-type, ADDI/ADDIU, SW: 4.
  - LW: 5.
  - BEQ, J: 3.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Outputs are combinational from the state register and opcode/funct. The state register updates on the clk rising edge.
- Reset: asynchronous and immediate. state=FETCH, illegal_op=0. All outputs are forced to 0 while rst_n=0. The first FETCH request issues on the first cycle after release.
- Reset mid-instruction abandons it with no partial write-enable pulse after the assertion edge.
- mem_ready high outside FETCH, MEM_READ or MEM_WRITE is ignored.

## Configuration
- MIPS_ILLEGAL_TRAP_EN defined:
  - An illegal opcode or funct goes to TRAP and sets illegal_op.
  - TRAP asserts no strobes and holds until reset.
- MIPS_ILLEGAL_TRAP_EN undefined:
  - An illegal opcode or funct behaves as a NOP. DECODE asserts instr_done and returns to FETCH (2 cycles).
  - illegal_op is tied to 0 and TRAP is unreachable.

## Test plan
- ADD (op 000000, funct 100000), mem_ready=1: states 0,1,6,7,0. alu_sel=010 in EXEC_R; reg_write and reg_dst=1 in R_WB; one instr_done pulse.
- LW with mem_ready low for 2 cycles in MEM_READ: 7 cycles total. mem_req=1 and iord=1 throughout MEM_READ. Then MEM_WB with mem_to_reg=1.
- BEQ with zero=1, then with zero=0: both take 3 cycles. pc_write_cond=1 and pc_src=1 in BRANCH in both cases; alu_sel=110.
- SLT, OR, AND, SUB in sequence: alu_sel 111, 001, 000, 110 respectively in EXEC_R.
- Opcode 111111: with MIPS_ILLEGAL_TRAP_EN, state goes to 15, illegal_op=1, and stays until rst_n pulse. Without the macro, return to FETCH after 2 cycles and illegal_op=0.
- rst_n asserted during MEM_WRITE with mem_ready=0: mem_we drops immediately, state=0. After release, FETCH restarts with mem_req=1, iord=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// one phase per clock, drives all datapath selects and write enables, and
// stalls on the memory ready handshake.
// Optional feature: define MIPS_ILLEGAL_TRAP_EN to trap on illegal opcode/funct
// (sticky illegal_op, FSM parks in TRAP until reset). Without it, illegal
// instructions retire as a two-cycle NOP.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_sel,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_I_WB      = 4'd11,
    S_TRAP      = 4'd15
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e     state_q, state_d;
  ctl_t       ctl_c, ctl_o;
  logic [2:0] r_alu_sel;
  logic       funct_ok, op_ok;

  // The zero flag gates pc_write_cond inside the datapath; the FSM itself
  // does not branch on it.
  logic unused_zero;
  assign unused_zero = zero;

  // Instruction legality and R-type ALU select decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can leave it unassigned (no latches).
    r_alu_sel = ALU_ADD;
    funct_ok  = 1'b1;
    op_ok     = 1'b1;
    case (funct)
      6'b100000: r_alu_sel = ALU_ADD;
      6'b100010: r_alu_sel = ALU_SUB;
      6'b100100: r_alu_sel = ALU_AND;
      6'b100101: r_alu_sel = ALU_OR;
      6'b101010: r_alu_sel = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
    case (opcode)
      OP_RTYPE:                                      op_ok = funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ADDIU: op_ok = 1'b1;
      default:                                       op_ok = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

`ifdef MIPS_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky illegal-instruction flag, set on the DECODE that enters TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                illegal_q <= 1'b0;
    else if (state_q == S_DECODE && !op_ok)    illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  // Next-state logic and per-state control outputs.
  always_comb begin
    ctl_c   = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctl_c.mem_req   = 1'b1;
        ctl_c.alu_src_b = 2'd1;
        ctl_c.alu_sel   = ALU_ADD;
        if (mem_ready) begin
          ctl_c.ir_write = 1'b1;
          ctl_c.pc_write = 1'b1;
          state_d        = S_DECODE;
        end
      end
      S_DECODE: begin
        ctl_c.alu_src_b = 2'd3;
        ctl_c.alu_sel   = ALU_ADD;
        if (!op_ok) begin
`ifdef MIPS_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          ctl_c.instr_done = 1'b1;
          state_d          = S_FETCH;
`endif
        end else begin
          case (opcode)
            OP_RTYPE:     state_d = S_EXEC_R;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_EXEC_I;
          endcase
        end
      end
      S_MEM_ADDR: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = 2'd2;
        ctl_c.alu_sel   = ALU_ADD;
        state_d         = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctl_c.mem_req = 1'b1;
        ctl_c.iord    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.mem_to_reg = 1'b1;
        ctl_c.instr_done = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctl_c.mem_req = 1'b1;
        ctl_c.mem_we  = 1'b1;
        ctl_c.iord    = 1'b1;
        if (mem_ready) begin
          ctl_c.instr_done = 1'b1;
          state_d          = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_sel   = r_alu_sel;
        state_d         = S_R_WB;
      end
      S_R_WB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.reg_dst    = 1'b1;
        ctl_c.instr_done = 1'b1;
        state_d          = S_FETCH;
      end
      S_EXEC_I: begin
        ctl_c.alu_src_a = 1'b1;
        ctl_c.alu_src_b = 2'd2;
        ctl_c.alu_sel   = ALU_ADD;
        state_d         = S_I_WB;
      end
      S_I_WB: begin
        ctl_c.reg_write  = 1'b1;
        ctl_c.instr_done = 1'b1;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        ctl_c.alu_src_a     = 1'b1;
        ctl_c.alu_sel       = ALU_SUB;
        ctl_c.pc_write_cond = 1'b1;
        ctl_c.pc_src        = 2'd1;
        ctl_c.instr_done    = 1'b1;
        state_d             = S_FETCH;
      end
      S_JUMP: begin
        ctl_c.pc_write   = 1'b1;
        ctl_c.pc_src     = 2'd2;
        ctl_c.instr_done = 1'b1;
        state_d          = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: outputs are masked by rst_n combinationally so a reset in the
  // middle of a write cycle kills the strobe immediately, not at the next edge.
  assign ctl_o = rst_n ? ctl_c : '0;

  assign mem_req       = ctl_o.mem_req;
  assign mem_we        = ctl_o.mem_we;
  assign iord          = ctl_o.iord;
  assign ir_write      = ctl_o.ir_write;
  assign pc_write      = ctl_o.pc_write;
  assign pc_write_cond = ctl_o.pc_write_cond;
  assign pc_src        = ctl_o.pc_src;
  assign alu_src_a     = ctl_o.alu_src_a;
  assign alu_src_b     = ctl_o.alu_src_b;
  assign alu_sel       = ctl_o.alu_sel;
  assign reg_write     = ctl_o.reg_write;
  assign reg_dst       = ctl_o.reg_dst;
  assign mem_to_reg    = ctl_o.mem_to_reg;
  assign instr_done    = ctl_o.instr_done;
  assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed test-plan sequences
// followed by random instructions, mem_ready stalls and zero values, checked
// cycle by cycle against an instruction-level reference model.
module tb_mips_multicycle_ctrl;

`ifdef MIPS_ILLEGAL_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  typedef enum {P_FETCH, P_DECODE, P_MADDR, P_MREAD, P_MWB, P_MWRITE,
                P_EXR, P_RWB, P_BR, P_JMP, P_EXI, P_IWB, P_TRAP} phase_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
  } ctl_t;

  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, instr_done, illegal_op;
  logic [2:0] alu_sel;
  logic [3:0] state;
  ctl_t       obs_ctl;

  int n_pass = 0;
  int n_chk  = 0;
  int done_cnt;
  logic exp_ill = 1'b0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_sel(alu_sel), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  assign obs_ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                    pc_src, alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
                    mem_to_reg, instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Debug state numbers published for each phase.
  function automatic logic [3:0] phase_num(phase_e p);
    case (p)
      P_FETCH:  return 4'd0;
      P_DECODE: return 4'd1;
      P_MADDR:  return 4'd2;
      P_MREAD:  return 4'd3;
      P_MWB:    return 4'd4;
      P_MWRITE: return 4'd5;
      P_EXR:    return 4'd6;
      P_RWB:    return 4'd7;
      P_BR:     return 4'd8;
      P_JMP:    return 4'd9;
      P_EXI:    return 4'd10;
      P_IWB:    return 4'd11;
      default:  return 4'd15;
    endcase
  endfunction

  // R-type funct table: {legal, alu code}.
  function automatic logic [3:0] r_alu(logic [5:0] fn);
    case (fn)
      6'h20:   return {1'b1, 3'b010};
      6'h22:   return {1'b1, 3'b110};
      6'h24:   return {1'b1, 3'b000};
      6'h25:   return {1'b1, 3'b001};
      6'h2a:   return {1'b1, 3'b111};
      default: return 4'b0000;
    endcase
  endfunction

  function automatic ctl_t exp_ctl(phase_e p, logic rdy, logic [5:0] fn, bit ill);
    ctl_t c;
    logic [3:0] ra;
    c  = '0;
    ra = r_alu(fn);
    case (p)
      P_FETCH:  begin c.mem_req = 1; c.alu_src_b = 1; c.alu_sel = 3'b010;
                      c.ir_write = rdy; c.pc_write = rdy; end
      P_DECODE: begin c.alu_src_b = 3; c.alu_sel = 3'b010;
                      c.instr_done = ill && !TRAP_BUILD; end
      P_MADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2; c.alu_sel = 3'b010; end
      P_MREAD:  begin c.mem_req = 1; c.iord = 1; end
      P_MWB:    begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      P_MWRITE: begin c.mem_req = 1; c.mem_we = 1; c.iord = 1; c.instr_done = rdy; end
      P_EXR:    begin c.alu_src_a = 1; c.alu_sel = ra[2:0]; end
      P_RWB:    begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
      P_BR:     begin c.alu_src_a = 1; c.alu_sel = 3'b110; c.pc_write_cond = 1;
                      c.pc_src = 1; c.instr_done = 1; end
      P_JMP:    begin c.pc_write = 1; c.pc_src = 2; c.instr_done = 1; end
      P_EXI:    begin c.alu_src_a = 1; c.alu_src_b = 2; c.alu_sel = 3'b010; end
      P_IWB:    begin c.reg_write = 1; c.instr_done = 1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock of one phase: drive at the falling edge, check 1ns later.
  task automatic step(phase_e p, logic rdy, logic [5:0] op, logic [5:0] fn,
                      bit ill, string tag);
    mem_ready = rdy;
    zero      = 1'($urandom);
    opcode    = op;
    funct     = fn;
    if (p == P_TRAP) exp_ill = 1'b1;
    #1;
    chk({tag, " state"},      32'(state),      32'(phase_num(p)));
    chk({tag, " ctl"},        32'(obs_ctl),    32'(exp_ctl(p, rdy, fn, ill)));
    chk({tag, " illegal_op"}, 32'(illegal_op), 32'(exp_ill));
    if (instr_done === 1'b1) done_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse(string tag);
    rst_n = 1'b0;
    exp_ill = 1'b0;
    #1;
    chk({tag, " rst state"}, 32'(state), 32'd0);
    chk({tag, " rst ctl"}, 32'(obs_ctl), 32'd0);
    chk({tag, " rst illegal_op"}, 32'(illegal_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run one instruction end-to-end. w_f / w_m are stall cycles (mem_ready=0)
  // in FETCH and in the data-memory phase.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, int w_f, int w_m, string tag);
    phase_e ph[$];
    logic [3:0] ra;
    bit ill;
    int waits;
    ra  = r_alu(fn);
    ill = 1'b0;
    ph.push_back(P_FETCH);
    ph.push_back(P_DECODE);
    case (op)
      6'h00:        if (ra[3]) begin ph.push_back(P_EXR); ph.push_back(P_RWB); end
                    else ill = 1'b1;
      6'h23:        begin ph.push_back(P_MADDR); ph.push_back(P_MREAD); ph.push_back(P_MWB); end
      6'h2b:        begin ph.push_back(P_MADDR); ph.push_back(P_MWRITE); end
      6'h04:        ph.push_back(P_BR);
      6'h02:        ph.push_back(P_JMP);
      6'h08, 6'h09: begin ph.push_back(P_EXI); ph.push_back(P_IWB); end
      default:      ill = 1'b1;
    endcase
    if (ill && TRAP_BUILD) for (int i = 0; i < 3; i++) ph.push_back(P_TRAP);
    done_cnt = 0;
    foreach (ph[i]) begin
      waits = (ph[i] == P_FETCH) ? w_f :
              (ph[i] == P_MREAD || ph[i] == P_MWRITE) ? w_m : 0;
      for (int k = 0; k <= waits; k++) begin
        if (ph[i] == P_FETCH || ph[i] == P_MREAD || ph[i] == P_MWRITE)
          step(ph[i], k == waits, op, fn, ill, tag);
        else
          step(ph[i], 1'($urandom), op, fn, ill, tag);
      end
    end
    chk({tag, " instr_done pulses"}, 32'(done_cnt), (ill && TRAP_BUILD) ? 32'd0 : 32'd1);
    if (ill && TRAP_BUILD) reset_pulse(tag);
  endtask

  logic [5:0] op_pool [10] = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h02,
                               6'h08, 6'h09, 6'h3f, 6'h11};
  logic [5:0] fn_pool [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h21};

  initial begin
    rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
    #2;
    chk("reset state", 32'(state), 32'd0);
    chk("reset ctl", 32'(obs_ctl), 32'd0);
    chk("reset illegal_op", 32'(illegal_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr(6'h00, 6'h20, 0, 0, "add");
    run_instr(6'h23, 6'h00, 0, 2, "lw stall");
    run_instr(6'h04, 6'h00, 0, 0, "beq a");
    run_instr(6'h04, 6'h00, 1, 0, "beq b");
    run_instr(6'h00, 6'h2a, 0, 0, "slt");
    run_instr(6'h00, 6'h25, 0, 0, "or");
    run_instr(6'h00, 6'h24, 0, 0, "and");
    run_instr(6'h00, 6'h22, 0, 0, "sub");
    run_instr(6'h3f, 6'h20, 0, 0, "illegal op");
    run_instr(6'h00, 6'h3f, 0, 0, "illegal funct");
    run_instr(6'h2b, 6'h00, 2, 1, "sw stall");
    run_instr(6'h02, 6'h00, 0, 0, "j");

    // Reset asserted while SW is stalled in MEM_WRITE.
    step(P_FETCH,  1'b1, 6'h2b, 6'h00, 1'b0, "sw rst");
    step(P_DECODE, 1'b1, 6'h2b, 6'h00, 1'b0, "sw rst");
    step(P_MADDR,  1'b1, 6'h2b, 6'h00, 1'b0, "sw rst");
    mem_ready = 1'b0;
    #1;
    chk("sw rst pre mem_we", 32'(mem_we), 32'd1);
    chk("sw rst pre state", 32'(state), 32'd5);
    #2;
    reset_pulse("sw rst");
    run_instr(6'h00, 6'h20, 0, 0, "post rst add");

    for (int n = 0; n < 60; n++) begin
      run_instr(op_pool[$urandom_range(0, 9)], fn_pool[$urandom_range(0, 6)],
                $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
